axi_ni_send_fsm: RTL

- Response-path controller of the AXI target network interface.
- Accepts AXI B (write response) and R (read data) beats from the attached slave and serialises them into NoC response packets: two header flits, then one payload flit per read beat.
- Retires the matching outstanding-ID tracking entry for each completed transaction.
- Pairs with the request-side receive FSM, which pushes those tracking entries.

---
 rtl/axi_ni_send_fsm.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/axi_ni_send_fsm.sv
// Response-path controller of the AXI target network interface: turns B and R
// beats into NoC response packets and retires the matching outstanding-ID entry.
module axi_ni_send_fsm #(
    parameter int MAX_SUPPORTED_IDS = 16,
    parameter int IDW               = 4,
    parameter int FLITW             = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         BVALID,
    input  logic [IDW-1:0]               BID,
    input  logic [1:0]                   BRESP,
    output logic                         BREADY,
    input  logic                         RVALID,
    input  logic [IDW-1:0]               RID,
    input  logic [FLITW-1:0]             RDATA,
    input  logic [1:0]                   RRESP,
    input  logic                         RLAST,
    output logic                         RREADY,
    input  logic [MAX_SUPPORTED_IDS-1:0] wrr_rempty,
    input  logic [MAX_SUPPORTED_IDS-1:0] rdr_rempty,
    output logic [MAX_SUPPORTED_IDS-1:0] wrr_rinc,
    output logic [MAX_SUPPORTED_IDS-1:0] rdr_rinc,
    output logic [IDW-1:0]               lookup_id,
    input  logic [FLITW-1:0]             lookup_route,
    output logic [FLITW-1:0]             flit_out,
    output logic                         flit_valid,
    output logic                         flit_tail,
    input  logic                         link_stall,
    output logic                         protocol_error
);

    typedef enum logic [2:0] {
        IDLE,
        WR_HDR0,
        WR_HDR1,
        RD_HDR0,
        RD_HDR1,
        RD_PAYLOAD
    } state_t;

    state_t         state_reg, state_next;
    logic [IDW-1:0] id_reg, id_next;
    logic [1:0]     resp_reg, resp_next;
    logic           rr_last_reg, rr_last_next;   // 1: R was granted last
    logic           grant_b, grant_r;

    logic [MAX_SUPPORTED_IDS-1:0] bid_sel, rid_sel, id_sel;
    logic [FLITW-1:0]             hdr_word;

    generate
        for (genvar gi = 0; gi < MAX_SUPPORTED_IDS; gi++) begin : g_id_decode
            assign bid_sel[gi] = (BID == IDW'(gi));
            assign rid_sel[gi] = (RID == IDW'(gi));
            assign id_sel[gi]  = (id_reg == IDW'(gi));
        end
    endgenerate

    always_comb begin
        hdr_word                  = '0;
        hdr_word[IDW-1:0]         = id_reg;
        hdr_word[IDW+1:IDW]       = resp_reg;
    end

    // Outputs are forced to their idle values while rst is high so a reset
    // landing on a final beat can never issue a tracking pop.
    always_comb begin
        state_next     = state_reg;
        id_next        = id_reg;
        resp_next      = resp_reg;
        rr_last_next   = rr_last_reg;
        grant_b        = 1'b0;
        grant_r        = 1'b0;
        BREADY         = 1'b0;
        RREADY         = 1'b0;
        flit_valid     = 1'b0;
        flit_tail      = 1'b0;
        flit_out       = '0;
        wrr_rinc       = '0;
        rdr_rinc       = '0;
        protocol_error = 1'b0;
        lookup_id      = '0;
        if (!rst) begin
            case (state_reg)
                IDLE: begin
                    grant_b = BVALID && (!RVALID || rr_last_reg);
                    grant_r = RVALID && !grant_b;
                    if (grant_b) begin
                        BREADY         = 1'b1;
                        wrr_rinc       = bid_sel;
                        protocol_error = |(wrr_rempty & bid_sel);
                        id_next        = BID;
                        resp_next      = BRESP;
                        rr_last_next   = 1'b0;
                        state_next     = WR_HDR0;
                    end else if (grant_r) begin
                        // First beat stays on the bus; it is consumed in RD_PAYLOAD.
                        protocol_error = |(rdr_rempty & rid_sel);
                        id_next        = RID;
                        resp_next      = RRESP;
                        rr_last_next   = 1'b1;
                        state_next     = RD_HDR0;
                    end
                end
                WR_HDR0, RD_HDR0: begin
                    lookup_id  = id_reg;
                    flit_valid = 1'b1;
                    flit_out   = lookup_route;
                    if (!link_stall) begin
                        state_next = (state_reg == WR_HDR0) ? WR_HDR1 : RD_HDR1;
                    end
                end
                WR_HDR1: begin
                    lookup_id  = id_reg;
                    flit_valid = 1'b1;
                    flit_out   = hdr_word;
                    flit_tail  = 1'b1;
                    if (!link_stall) begin
                        state_next = IDLE;
                    end
                end
                RD_HDR1: begin
                    lookup_id           = id_reg;
                    flit_valid          = 1'b1;
                    flit_out            = hdr_word;
                    flit_out[FLITW-1]   = 1'b1;
                    if (!link_stall) begin
                        state_next = RD_PAYLOAD;
                    end
                end
                RD_PAYLOAD: begin
                    lookup_id  = id_reg;
                    flit_valid = RVALID;
                    flit_out   = RDATA;
                    flit_tail  = RLAST;
                    RREADY     = !link_stall;
                    if (RVALID && !link_stall && RLAST) begin
                        rdr_rinc   = id_sel;
                        state_next = IDLE;
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            id_reg      <= '0;
            resp_reg    <= '0;
            rr_last_reg <= 1'b1;
        end else begin
            state_reg   <= state_next;
            id_reg      <= id_next;
            resp_reg    <= resp_next;
            rr_last_reg <= rr_last_next;
        end
    end

endmodule
